// File: rtl/edid_pkg.sv
// Shared types and byte offsets for the EDID base-block parser.
package edid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_DONE   = 2'd3
    } edid_state_t;

    localparam int unsigned BLOCK_BYTES = 128;
    localparam int unsigned DTD_OFFSET  = 54;

    // Fixed 8-byte EDID header, byte 0 in the most significant position.
    localparam logic [63:0] HEADER_PAT = 64'h00FF_FFFF_FFFF_FF00;

    localparam int unsigned OFF_MFG       = 8;
    localparam int unsigned OFF_PROD      = 10;
    localparam int unsigned OFF_VER       = 18;
    localparam int unsigned OFF_REV       = 19;
    localparam int unsigned OFF_PIXCLK_LO = DTD_OFFSET;
    localparam int unsigned OFF_PIXCLK_HI = DTD_OFFSET + 1;
    localparam int unsigned OFF_HACT_LO   = 56;
    localparam int unsigned OFF_HACT_HI   = 58;
    localparam int unsigned OFF_VACT_LO   = 59;
    localparam int unsigned OFF_VACT_HI   = 61;
    localparam int unsigned OFF_EXT       = 126;
    localparam int unsigned OFF_CHECKSUM  = 127;

    localparam logic [6:0] LAST_HDR_IDX = 7'd7;
    localparam logic [6:0] LAST_IDX     = 7'(BLOCK_BYTES - 1);

endpackage

// File: rtl/edid_byte_capture.sv
// Latches one EDID byte when the accepted index matches IDX.
module edid_byte_capture #(
    parameter int unsigned IDX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       strobe,
    input  logic [6:0] index,
    input  logic [7:0] data,
    output logic [7:0] q
);

    // Clear on start, otherwise capture the matching accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 8'h00;
        end else if (clr) begin
            q <= 8'h00;
        end else if (strobe && (index == 7'(IDX))) begin
            q <= data;
        end
    end

endmodule

// File: rtl/edid_block_parser.sv
// EDID base-block parser: header check, mod-256 checksum, field capture.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start, no bytes accepted
// ST_HEADER | accepting bytes 0-7, comparing against the fixed header
// ST_BODY   | accepting bytes 8-127, accumulating the checksum
// ST_DONE   | block complete, results held until start
module edid_block_parser
    import edid_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        done,
    output logic        header_ok,
    output logic        checksum_ok,
    output logic [15:0] mfg_id,
    output logic [15:0] product_code,
    output logic [7:0]  edid_ver,
    output logic [7:0]  edid_rev,
    output logic [15:0] pixclk_10khz,
    output logic [11:0] h_active,
    output logic [11:0] v_active,
    output logic [7:0]  ext_count,
    output logic [6:0]  byte_index
);

    localparam int unsigned CAP_N = 13;
    localparam int unsigned CAP_IDX [CAP_N] = '{
        OFF_MFG, OFF_MFG + 1, OFF_PROD, OFF_PROD + 1, OFF_VER, OFF_REV,
        OFF_PIXCLK_LO, OFF_PIXCLK_HI, OFF_HACT_LO, OFF_HACT_HI,
        OFF_VACT_LO, OFF_VACT_HI, OFF_EXT
    };

    edid_state_t state;
    logic [7:0]  acc;
    logic [7:0]  acc_next;
    logic [7:0]  hdr_byte;
    logic        hdr_match;
    logic        accept;
    logic [7:0]  cap [CAP_N];

    // A start in the same cycle drops the byte so the new block begins clean.
    always_comb begin
        accept   = byte_valid && byte_ready && !start;
        acc_next = acc + byte_data;
        hdr_byte = HEADER_PAT[{3'd7 - byte_index[2:0], 3'b000} +: 8];
    end

    // Sequencing, checksum accumulation and header comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_ready  <= 1'b0;
            done        <= 1'b0;
            header_ok   <= 1'b0;
            checksum_ok <= 1'b0;
            byte_index  <= 7'd0;
            acc         <= 8'h00;
            hdr_match   <= 1'b1;
        end else if (start) begin
            state       <= ST_HEADER;
            byte_ready  <= 1'b1;
            done        <= 1'b0;
            header_ok   <= 1'b0;
            checksum_ok <= 1'b0;
            byte_index  <= 7'd0;
            acc         <= 8'h00;
            hdr_match   <= 1'b1;
        end else begin
            case (state)
                ST_HEADER: begin
                    if (accept) begin
                        byte_index <= byte_index + 7'd1;
                        acc        <= acc_next;
                        if (byte_data != hdr_byte) begin
                            hdr_match <= 1'b0;
                        end
                        if (byte_index == LAST_HDR_IDX) begin
                            state <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        byte_index <= byte_index + 7'd1;
                        acc        <= acc_next;
                        if (byte_index == LAST_IDX) begin
                            state       <= ST_DONE;
                            byte_ready  <= 1'b0;
                            done        <= 1'b1;
                            header_ok   <= hdr_match;
                            checksum_ok <= (acc_next == 8'h00);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < CAP_N; g++) begin : g_cap
        edid_byte_capture #(
            .IDX(CAP_IDX[g])
        ) u_cap (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .strobe(accept),
            .index (byte_index),
            .data  (byte_data),
            .q     (cap[g])
        );
    end

    // Only the upper nibble of bytes 58/61 is active size; the rest is blanking.
    always_comb begin
        mfg_id       = {cap[0], cap[1]};
        product_code = {cap[3], cap[2]};
        edid_ver     = cap[4];
        edid_rev     = cap[5];
        pixclk_10khz = {cap[7], cap[6]};
        h_active     = {cap[9][7:4], cap[8]};
        v_active     = {cap[11][7:4], cap[10]};
        ext_count    = cap[12];
    end

endmodule

// File: tb/tb_edid_block_parser.sv
// Self-checking bench for edid_block_parser.
module tb_edid_block_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        done;
    logic        header_ok;
    logic        checksum_ok;
    logic [15:0] mfg_id;
    logic [15:0] product_code;
    logic [7:0]  edid_ver;
    logic [7:0]  edid_rev;
    logic [15:0] pixclk_10khz;
    logic [11:0] h_active;
    logic [11:0] v_active;
    logic [7:0]  ext_count;
    logic [6:0]  byte_index;

    edid_block_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .done        (done),
        .header_ok   (header_ok),
        .checksum_ok (checksum_ok),
        .mfg_id      (mfg_id),
        .product_code(product_code),
        .edid_ver    (edid_ver),
        .edid_rev    (edid_rev),
        .pixclk_10khz(pixclk_10khz),
        .h_active    (h_active),
        .v_active    (v_active),
        .ext_count   (ext_count),
        .byte_index  (byte_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] blk [128];
    logic [7:0] hdr_pat [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    typedef struct {
        string       name;
        logic [7:0]  b3;
        bit          bump100;
        int          gap_pct;
        bit          exp_hok;
        bit          exp_cok;
        logic [15:0] exp_pix;
        logic [11:0] exp_h;
        logic [11:0] exp_v;
        logic [15:0] exp_mfg;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sum_to(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + blk[i];
        return s;
    endfunction

    // Reference 1080p block; byte 127 makes the sum zero.
    task automatic build_base(input logic [7:0] b3);
        for (int i = 0; i < 128; i++) blk[i] = 8'h00;
        for (int i = 0; i < 8; i++) blk[i] = hdr_pat[i];
        blk[3]  = b3;
        blk[8]  = 8'h10; blk[9]  = 8'hAC;
        blk[10] = 8'h34; blk[11] = 8'h12;
        blk[18] = 8'h01; blk[19] = 8'h03;
        blk[54] = 8'h02; blk[55] = 8'h3A;
        blk[56] = 8'h80; blk[58] = 8'h70;
        blk[59] = 8'h38; blk[61] = 8'h40;
        blk[126] = 8'h00;
        blk[127] = 8'h00 - sum_to(127);
    endtask

    // Expected results derived directly from the byte array.
    task automatic model_check(input string tag);
        bit hok = 1'b1;
        for (int i = 0; i < 8; i++) if (blk[i] != hdr_pat[i]) hok = 1'b0;
        check({tag, ".done"},   32'(done), 32'd1);
        check({tag, ".hdr"},    32'(header_ok), 32'(hok));
        check({tag, ".csum"},   32'(checksum_ok), 32'(sum_to(128) == 8'h00));
        check({tag, ".mfg"},    32'(mfg_id), 32'(blk[8]) * 256 + 32'(blk[9]));
        check({tag, ".prod"},   32'(product_code), 32'(blk[11]) * 256 + 32'(blk[10]));
        check({tag, ".ver"},    32'(edid_ver), 32'(blk[18]));
        check({tag, ".rev"},    32'(edid_rev), 32'(blk[19]));
        check({tag, ".pix"},    32'(pixclk_10khz), 32'(blk[55]) * 256 + 32'(blk[54]));
        check({tag, ".hact"},   32'(h_active), (32'(blk[58]) / 16) * 256 + 32'(blk[56]));
        check({tag, ".vact"},   32'(v_active), (32'(blk[61]) / 16) * 256 + 32'(blk[59]));
        check({tag, ".ext"},    32'(ext_count), 32'(blk[126]));
        check({tag, ".idx"},    32'(byte_index), 32'd0);
        check({tag, ".ready"},  32'(byte_ready), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams blk[0..n-1] with random valid gaps; ends on a negedge with valid low.
    task automatic send_n(input int n, input int gap_pct);
        int k = 0;
        int budget = 4000;
        while (k < n && budget > 0) begin
            @(negedge clk);
            start = 1'b0;
            byte_valid = ($urandom_range(99) >= 32'(gap_pct));
            byte_data = byte_valid ? blk[k] : 8'($urandom);
            if (byte_valid && byte_ready) begin
                if (k == 127) check("done_before_last_edge", 32'(done), 32'd0);
                k++;
            end
            @(posedge clk);
            budget--;
        end
        if (k < n) check("stream_timeout", 32'(k), 32'(n));
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle_pulses(input string tag, input logic [6:0] exp_idx);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data = 8'($urandom);
            check({tag, ".ready"}, 32'(byte_ready), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check({tag, ".idx"}, 32'(byte_index), 32'(exp_idx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"valid1080p", 8'hFF, 1'b0, 0,  1'b1, 1'b1, 16'd14850, 12'd1920, 12'd1080, 16'h10AC};
        vecs[1] = '{"badheader",  8'hFE, 1'b0, 0,  1'b0, 1'b1, 16'd14850, 12'd1920, 12'd1080, 16'h10AC};
        vecs[2] = '{"badsum",     8'hFF, 1'b1, 0,  1'b1, 1'b0, 16'd14850, 12'd1920, 12'd1080, 16'h10AC};
        vecs[3] = '{"gaps",       8'hFF, 1'b0, 50, 1'b1, 1'b1, 16'd14850, 12'd1920, 12'd1080, 16'h10AC};

        repeat (3) @(negedge clk);
        check("rst.ready", 32'(byte_ready), 32'd0);
        check("rst.done",  32'(done), 32'd0);
        check("rst.hdr",   32'(header_ok), 32'd0);
        check("rst.csum",  32'(checksum_ok), 32'd0);
        check("rst.mfg",   32'(mfg_id), 32'd0);
        check("rst.idx",   32'(byte_index), 32'd0);
        rst_n = 1'b1;

        idle_pulses("idle", 7'd0);

        foreach (vecs[v]) begin
            build_base(vecs[v].b3);
            if (vecs[v].bump100) blk[100] = blk[100] + 8'd1;
            pulse_start();
            send_n(128, vecs[v].gap_pct);
            check({vecs[v].name, ".done"}, 32'(done), 32'd1);
            check({vecs[v].name, ".hdr"},  32'(header_ok), 32'(vecs[v].exp_hok));
            check({vecs[v].name, ".csum"}, 32'(checksum_ok), 32'(vecs[v].exp_cok));
            check({vecs[v].name, ".pix"},  32'(pixclk_10khz), 32'(vecs[v].exp_pix));
            check({vecs[v].name, ".hact"}, 32'(h_active), 32'(vecs[v].exp_h));
            check({vecs[v].name, ".vact"}, 32'(v_active), 32'(vecs[v].exp_v));
            check({vecs[v].name, ".mfg"},  32'(mfg_id), 32'(vecs[v].exp_mfg));
            model_check(vecs[v].name);
        end

        idle_pulses("donehold", 7'd0);
        model_check("donehold");

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 128; i++) blk[i] = 8'($urandom);
            if ($urandom_range(1) == 1) for (int i = 0; i < 8; i++) blk[i] = hdr_pat[i];
            if ($urandom_range(1) == 1) blk[127] = 8'h00 - sum_to(127);
            pulse_start();
            send_n(128, 50);
            model_check($sformatf("rand%0d", r));
        end

        // Restart at index 40; start coincides with a valid byte that must be dropped.
        build_base(8'hFF);
        pulse_start();
        send_n(40, 30);
        check("restart.idx40", 32'(byte_index), 32'd40);
        check("restart.mfg_live", 32'(mfg_id), 32'h10AC);
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b0;
        check("restart.idx", 32'(byte_index), 32'd0);
        check("restart.mfg_clr", 32'(mfg_id), 32'd0);
        check("restart.done", 32'(done), 32'd0);
        send_n(128, 20);
        model_check("restart");
        check("restart.hdr_ok", 32'(header_ok), 32'd1);
        check("restart.csum_ok", 32'(checksum_ok), 32'd1);

        // Asynchronous reset mid-block at index 70.
        pulse_start();
        send_n(70, 0);
        check("midrst.idx70", 32'(byte_index), 32'd70);
        rst_n = 1'b0;
        #1;
        check("midrst.idx",   32'(byte_index), 32'd0);
        check("midrst.ready", 32'(byte_ready), 32'd0);
        check("midrst.mfg",   32'(mfg_id), 32'd0);
        check("midrst.pix",   32'(pixclk_10khz), 32'd0);
        check("midrst.hact",  32'(h_active), 32'd0);
        check("midrst.done",  32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_pulses("postrst", 7'd0);
        pulse_start();
        send_n(128, 40);
        model_check("postrst");
        check("postrst.hdr_ok", 32'(header_ok), 32'd1);
        check("postrst.csum_ok", 32'(checksum_ok), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
